// File: rtl/register_file_pkg.sv
// Shared constants and types for the RV32I integer register file.
package register_file_pkg;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = $clog2(NUM_REGS);

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       reg_data_t;
endpackage

// File: rtl/rv32_register_file_sva.sv
// Checkers bound into the register file: x0 always reads zero, and storage
// holds still across any non-reset cycle without a write enable.
module rv32_register_file_sva #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input logic                          clk,
    input logic                          rst,
    input logic                          wr_en,
    input logic [AW-1:0]                 rd_reg_1,
    input logic [AW-1:0]                 rd_reg_2,
    input logic [XLEN-1:0]               rd_data_1,
    input logic [XLEN-1:0]               rd_data_2,
    input logic [NUM_REGS-1:0][XLEN-1:0] regs
);

    // Storage is undefined before the first reset, so hold checks start after it.
    logic past_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            past_valid <= 1'b1;
        end
    end

    always_comb begin
        if (rd_reg_1 == '0) assert (rd_data_1 == '0) else $error("x0 read nonzero on port 1");
        if (rd_reg_2 == '0) assert (rd_data_2 == '0) else $error("x0 read nonzero on port 2");
    end

    hold_without_write: assert property (@(posedge clk)
        (past_valid && !$past(rst) && !$past(wr_en)) |-> (regs == $past(regs)))
        else $error("register contents changed with wr_en low");

endmodule

bind rv32_register_file rv32_register_file_sva #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS)
) u_sva (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .rd_reg_1  (rd_reg_1),
    .rd_reg_2  (rd_reg_2),
    .rd_data_1 (rd_data_1),
    .rd_data_2 (rd_data_2),
    .regs      (regs)
);

// File: rtl/rv32_register_file.sv
// RV32I register file: two combinational read ports, one synchronous write port,
// x0 hardwired to zero, no write-through bypass.
module rv32_register_file
    import register_file_pkg::*;
#(
    parameter int XLEN     = register_file_pkg::XLEN,
    parameter int NUM_REGS = register_file_pkg::NUM_REGS,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_reg,
    input  logic [XLEN-1:0] wr_data,
    input  logic [AW-1:0]   rd_reg_1,
    input  logic [AW-1:0]   rd_reg_2,
    output logic [XLEN-1:0] rd_data_1,
    output logic [XLEN-1:0] rd_data_2
);

    // Slot 0 exists only so indexing stays simple; it is never written and
    // the read muxes force x0 to zero regardless of its contents.
    logic [NUM_REGS-1:0][XLEN-1:0] regs;

    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '0;
        end else if (wr_en && (wr_reg != '0)) begin
            regs[wr_reg] <= wr_data;
        end
    end

    assign rd_data_1 = (rd_reg_1 == '0) ? '0 : regs[rd_reg_1];
    assign rd_data_2 = (rd_reg_2 == '0) ? '0 : regs[rd_reg_2];

endmodule

// File: tb/tb_rv32_register_file.sv
// Self-checking bench: directed cases plus a randomized run against an array model.
module tb_rv32_register_file;
    import register_file_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    logic      wr_en;
    reg_addr_t wr_reg;
    reg_data_t wr_data;
    reg_addr_t rd_reg_1, rd_reg_2;
    reg_data_t rd_data_1, rd_data_2;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: architectural register values; x0 entry stays 0.
    reg_data_t model [NUM_REGS];

    rv32_register_file dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_reg    (wr_reg),
        .wr_data   (wr_data),
        .rd_reg_1  (rd_reg_1),
        .rd_reg_2  (rd_reg_2),
        .rd_data_1 (rd_data_1),
        .rd_data_2 (rd_data_2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input reg_data_t obs, input reg_data_t exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, applying the architectural update to the model.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        end else if (wr_en && wr_reg != 0) begin
            model[wr_reg] = wr_data;
        end
        #1;
    endtask

    task automatic set_rd(input reg_addr_t a1, input reg_addr_t a2);
        rd_reg_1 = a1;
        rd_reg_2 = a2;
        #2;
    endtask

    task automatic do_write(input reg_addr_t a, input reg_data_t d);
        wr_en = 1'b1; wr_reg = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_reg = '0; wr_data = '0;
        rd_reg_1 = '0; rd_reg_2 = '0;
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        tick(); tick();
        rst = 1'b0;

        set_rd(0, 0);
        chk("reset_x0_p1", rd_data_1, 32'h0);
        chk("reset_x0_p2", rd_data_2, 32'h0);
        set_rd(9, 31);
        chk("reset_x9", rd_data_1, 32'h0);
        chk("reset_x31", rd_data_2, 32'h0);

        // Same-cycle read of the register being written returns the old value.
        wr_en = 1'b1; wr_reg = 5; wr_data = 32'hDEADBEEF;
        set_rd(5, 5);
        chk("x5_old_value", rd_data_1, 32'h0);
        tick();
        wr_en = 1'b0;
        set_rd(5, 5);
        chk("x5_p1", rd_data_1, 32'hDEADBEEF);
        chk("x5_p2", rd_data_2, 32'hDEADBEEF);

        do_write(15, 32'hFFFF0000);
        do_write(15, 32'h0000FFFF);
        set_rd(15, 5);
        chk("x15_overwrite", rd_data_1, 32'h0000FFFF);
        repeat (10) tick();
        set_rd(5, 15);
        chk("x15_persist", rd_data_2, 32'h0000FFFF);
        chk("x5_persist", rd_data_1, 32'hDEADBEEF);

        do_write(0, 32'hFFFFFFFF);
        set_rd(0, 0);
        chk("x0_write_p1", rd_data_1, 32'h0);
        chk("x0_write_p2", rd_data_2, 32'h0);

        do_write(3, 32'h0BADF00D);
        wr_en = 1'b0; wr_reg = 3; wr_data = 32'h12345678;
        tick();
        set_rd(3, 3);
        chk("x3_disabled_write", rd_data_1, 32'h0BADF00D);

        do_write(20, 32'hFFFFFFFF);
        set_rd(20, 0);
        chk("x20_ones", rd_data_1, 32'hFFFFFFFF);
        do_write(20, 32'h0);
        set_rd(20, 20);
        chk("x20_zero", rd_data_2, 32'h0);

        // Reset beats a simultaneous write.
        rst = 1'b1; wr_en = 1'b1; wr_reg = 7; wr_data = 32'hA5A5A5A5;
        tick();
        rst = 1'b0; wr_en = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            set_rd(reg_addr_t'(r), reg_addr_t'(NUM_REGS - 1 - r));
            chk($sformatf("rst_clear_p1_x%0d", r), rd_data_1, 32'h0);
            chk($sformatf("rst_clear_p2_x%0d", NUM_REGS - 1 - r), rd_data_2, 32'h0);
        end

        // Random regression against the model.
        for (int c = 0; c < 1000; c++) begin
            rst     = ($urandom_range(63) == 0);
            wr_en   = $urandom_range(1);
            wr_reg  = reg_addr_t'($urandom_range(NUM_REGS - 1));
            wr_data = (($urandom_range(7) == 0) ? 32'h0 : reg_data_t'($urandom));
            set_rd(reg_addr_t'($urandom_range(NUM_REGS - 1)),
                   reg_addr_t'($urandom_range(NUM_REGS - 1)));
            chk($sformatf("rand%0d_p1_x%0d", c, rd_reg_1), rd_data_1, model[rd_reg_1]);
            chk($sformatf("rand%0d_p2_x%0d", c, rd_reg_2), rd_data_2, model[rd_reg_2]);
            tick();
        end
        rst = 1'b0; wr_en = 1'b0;

        // Final sweep of every register through both ports.
        for (int r = 0; r < NUM_REGS; r++) begin
            set_rd(reg_addr_t'(r), reg_addr_t'(r));
            chk($sformatf("sweep_p1_x%0d", r), rd_data_1, model[r]);
            chk($sformatf("sweep_p2_x%0d", r), rd_data_2, model[r]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
